// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU: op-code field layout, named op codes,
// output-select encoding and the controller state type.
package alu_pkg;

  localparam int OP_AINV   = 3;
  localparam int OP_BINV   = 2;
  localparam int OP_SEL_HI = 1;
  localparam int OP_SEL_LO = 0;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    SEL_AND  = 2'b00,
    SEL_OR   = 2'b01,
    SEL_SUM  = 2'b10,
    SEL_LESS = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_serial_if.sv
// Request/response bundle of the serial ALU: operand handshake in, result
// handshake with flags out.
interface alu_serial_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, cout, ovf, zero
  );
endinterface

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU slice: optional operand inversion, ripple add and
// AND/OR/SUM select. LESS yields zeros; the top patches bit 0 for SLT.
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_ainv,
  input  logic             i_binv,
  input  logic             i_cin,
  input  sel_e             i_sel,
  output logic [SLICE-1:0] o_out,
  output logic             o_cout,
  output logic             o_msb_cin
);
  logic [SLICE-1:0] w_a;
  logic [SLICE-1:0] w_b;
  logic [SLICE-1:0] w_sum;

  assign w_a = i_ainv ? ~i_a : i_a;
  assign w_b = i_binv ? ~i_b : i_b;
  assign {o_cout, w_sum} = {1'b0, w_a} + {1'b0, w_b} + {{SLICE{1'b0}}, i_cin};

  // Carry into the slice MSB, recovered from the sum bit rather than a ripple chain.
  assign o_msb_cin = w_a[SLICE-1] ^ w_b[SLICE-1] ^ w_sum[SLICE-1];

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    o_out = '0;
    unique case (i_sel)
      SEL_AND:  o_out = w_a & w_b;
      SEL_OR:   o_out = w_a | w_b;
      SEL_SUM:  o_out = w_sum;
      SEL_LESS: o_out = '0;
    endcase
  end
endmodule

// File: rtl/alu_serial.sv
// Multi-cycle integer ALU: accepts an operand pair, processes SLICE bits per
// cycle LSB first through alu_slice, and returns the result with flags.
module alu_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_serial_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (WIDTH % SLICE != 0) begin : g_width_check
    $error("alu_serial: WIDTH (%0d) must be a multiple of SLICE (%0d)", WIDTH, SLICE);
  end

  state_e           r_state;
  state_e           w_next;
  logic [CW-1:0]    r_k;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic             w_ainv;
  logic             w_binv;
  sel_e             w_sel;
  logic [IW-1:0]    w_base;
  logic             w_last;
  logic [SLICE-1:0] w_out;
  logic             w_cout;
  logic             w_msb_cin;
  logic             w_ovf;
  logic             w_less;

  assign w_ainv = r_op[OP_AINV];
  assign w_binv = r_op[OP_BINV];
  assign w_sel  = sel_e'(r_op[OP_SEL_HI:OP_SEL_LO]);
  assign w_base = IW'(int'(r_k) * SLICE);
  assign w_last = (r_k == CW'(NSLICE - 1));

  alu_slice #(.SLICE(SLICE)) u_slice (
    .i_a       (r_a[w_base +: SLICE]),
    .i_b       (r_b[w_base +: SLICE]),
    .i_ainv    (w_ainv),
    .i_binv    (w_binv),
    .i_cin     (r_carry),
    .i_sel     (w_sel),
    .o_out     (w_out),
    .o_cout    (w_cout),
    .o_msb_cin (w_msb_cin)
  );

  // Flags are only meaningful on the last slice, where the slice MSB is bit WIDTH-1.
  assign w_ovf  = w_msb_cin ^ w_cout;
  assign w_less = (r_a[WIDTH-1] ^ w_ainv) ^ (r_b[WIDTH-1] ^ w_binv) ^ w_msb_cin ^ w_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_next = BUSY;
      BUSY:    if (w_last)        w_next = DONE;
      DONE:    if (bus.out_ready) w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset as well so the slice never evaluates X after power-up.
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_AND;
      r_k      <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a     <= bus.a;
          r_b     <= bus.b;
          r_op    <= bus.op;
          r_k     <= '0;
          r_carry <= bus.op[OP_BINV];
        end
        BUSY: begin
          r_result[w_base +: SLICE] <= w_out;
          r_carry                   <= w_cout;
          r_k                       <= r_k + 1'b1;
          if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            if (w_sel == SEL_LESS) r_result[0] <= w_less;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;
  assign bus.zero   = (r_result == '0);
endmodule
